// File: rtl/rf_pkg.sv
// Shared constants and types for the decode-stage register bank.
// Optional build macro: RF_BYPASS_EN (write-to-read forwarding).
package rf_pkg;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;
    localparam int RF_NRD  = 2;
    localparam int RF_AW   = $clog2(RF_NREG);
    // Register 0 is hard-wired to zero and never tracked as busy.
    localparam int R0_IDX  = 0;

    typedef logic [RF_AW-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/write-back and the register bank.
// master = core side driving requests, slave = register bank.
// Optional build macro: RF_BYPASS_EN (affects the slave's behaviour only).
interface regfile_sb_if
    import rf_pkg::*;
#(
    parameter int DW   = RF_DW,
    parameter int NREG = RF_NREG,
    parameter int NRD  = RF_NRD
) ();
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_used;
    logic [NRD*DW-1:0] rd_data;
    logic              iss_vld;
    logic [AW-1:0]     iss_rd;
    logic              iss_wr;
    logic              stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [AW:0]       busy_cnt;

    modport master (
        output rd_addr, rd_used, iss_vld, iss_rd, iss_wr, wr_en, wr_addr, wr_data,
        input  rd_data, stall, busy_cnt
    );

    modport slave (
        input  rd_addr, rd_used, iss_vld, iss_rd, iss_wr, wr_en, wr_addr, wr_data,
        output rd_data, stall, busy_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking, busy population counter and RAW/WAW stall.
// Optional build macro: RF_BYPASS_EN -- a register being written back this
// cycle is treated as already free when deciding whether to stall.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREG = RF_NREG,
    parameter  int NRD  = RF_NRD,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_used,
    input  logic              iss_vld,
    input  logic [AW-1:0]     iss_rd,
    input  logic              iss_wr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    output logic              stall,
    output logic [AW:0]       busy_cnt
);
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] busy_r;
    logic [AW:0]     cnt_r;
    logic [NREG-1:0] busy_eff_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic            clr_s;
    logic            set_s;
    logic            hazard_s;
    logic            stall_s;
    logic            inc_s;
    logic            dec_s;

    // Write-back clears and accepted issues set; R0 is excluded from both.
    assign clr_s      = wr_en && (wr_addr != AW'(R0_IDX));
    assign clr_mask_s = clr_s ? (ONE_HOT0 << wr_addr) : {NREG{1'b0}};
    assign set_s      = iss_vld && !stall_s && iss_wr && (iss_rd != AW'(R0_IDX));
    assign set_mask_s = set_s ? (ONE_HOT0 << iss_rd) : {NREG{1'b0}};

`ifdef RF_BYPASS_EN
    // The value being written back is forwarded, so its busy bit no longer blocks.
    assign busy_eff_s = busy_r & ~clr_mask_s;
`else
    assign busy_eff_s = busy_r;
`endif

    // RAW on any used source port, WAW on the destination; only while issuing.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            hazard_s = hazard_s | (rd_used[i] & busy_eff_s[rd_addr[i*AW +: AW]]);
        end
        hazard_s = hazard_s | (iss_wr & busy_eff_s[iss_rd]);
        stall_s  = iss_vld & hazard_s;
    end

    // Counter moves only when a bit actually changes; a same-cycle set on the
    // register being cleared leaves it busy, so that clear does not count.
    assign inc_s = set_s && !busy_r[iss_rd];
    assign dec_s = clr_s && busy_r[wr_addr] && !(set_s && (iss_rd == wr_addr));

    // Busy vector and its population count; the set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
            cnt_r  <= cnt_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
        end
    end

    assign stall    = stall_s;
    assign busy_cnt = cnt_r;
endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register bank: NRD combinational read ports, one write-back
// port, and an issue-time busy scoreboard for RAW/WAW stalls.
// Optional build macro: RF_BYPASS_EN -- forward write-back data to reads
// in the same cycle and release the matching busy bit for the stall check.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DW   = RF_DW,
    parameter int NREG = RF_NREG,
    parameter int NRD  = RF_NRD
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0] regs_r [NREG];
    logic          wr_ok_s;

    // R0 is never written, so it keeps its reset value of zero.
    assign wr_ok_s = bus.wr_en && (bus.wr_addr != AW'(R0_IDX));

    // Register storage: cleared by reset, written by write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read muxes, one per port.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr_s;
        assign addr_s = bus.rd_addr[g*AW +: AW];
`ifdef RF_BYPASS_EN
        assign bus.rd_data[g*DW +: DW] = (wr_ok_s && (addr_s == bus.wr_addr)) ?
                                         bus.wr_data : regs_r[addr_s];
`else
        assign bus.rd_data[g*DW +: DW] = regs_r[addr_s];
`endif
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (bus.rd_addr),
        .rd_used  (bus.rd_used),
        .iss_vld  (bus.iss_vld),
        .iss_rd   (bus.iss_rd),
        .iss_wr   (bus.iss_wr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .stall    (bus.stall),
        .busy_cnt (bus.busy_cnt)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (DW=32, NREG=32, NRD=2).
// Expectations follow RF_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    string       name_q[$];
    logic [31:0] val_q[$];
    string       nm;
    logic [31:0] ev;
    logic [31:0] act;

    regfile_sb_if #(.DW(32), .NREG(32), .NRD(2)) bus ();

    regfile_sb #(.DW(32), .NREG(32), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string n, input logic [31:0] v);
        name_q.push_back(n);
        val_q.push_back(v);
    endtask

    task automatic pop();
        if (name_q.size() == 0) begin
            nm = "empty_queue";
            ev = 32'hxxxx_xxxx;
        end else begin
            nm = name_q.pop_front();
            ev = val_q.pop_front();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr = 10'd0;
        bus.rd_used = 2'b00;
        bus.iss_vld = 1'b0;
        bus.iss_rd  = 5'd0;
        bus.iss_wr  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'd0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        bus.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_vld = 1'b1;
        bus.iss_wr  = 1'b1;
        bus.iss_rd  = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic test_reset();
        idle();
        wb(5'd5, 32'h0000_0011);
        cyc();
        idle();
        wb(5'd9, 32'h0000_0022);
        issue(5'd4);
        cyc();
        idle();
        set_rd(0, 5'd5);
        push("preload_rd5", 32'h0000_0011);
        push("preload_cnt", 32'd1);
        #1;
        act = bus.rd_data[31:0]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_rd(0, 5'd5);
        set_rd(1, 5'd9);
        issue(5'd4);
        push("reset_rd0", 32'd0);
        push("reset_rd1", 32'd0);
        push("reset_cnt", 32'd0);
        push("reset_stall", 32'd0);
        #1;
        act = bus.rd_data[31:0];  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[63:32]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.busy_cnt);  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.stall);     pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        idle();
    endtask

    task automatic test_write_read();
        wb(5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5);
`ifdef RF_BYPASS_EN
        push("wr_same_cycle", 32'hDEAD_BEEF);
`else
        push("wr_same_cycle", 32'd0);
`endif
        #1;
        act = bus.rd_data[31:0]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        bus.wr_en = 1'b0;
        push("wr_next_cycle", 32'hDEAD_BEEF);
        push("wr_nonbusy_cnt", 32'd0);
        #1;
        act = bus.rd_data[31:0]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        wb(5'd0, 32'h0000_1234);
        set_rd(0, 5'd0);
        push("r0_bypass", 32'd0);
        #1;
        act = bus.rd_data[31:0]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd5);
        push("r0_after_write", 32'd0);
        push("rd1_reg5", 32'hDEAD_BEEF);
        #1;
        act = bus.rd_data[31:0];  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[63:32]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
    endtask

    task automatic test_raw();
        idle();
        issue(5'd7);
        push("issue7_stall", 32'd0);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        idle();
        push("issue7_cnt", 32'd1);
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        bus.iss_vld = 1'b1;
        set_rd(1, 5'd7);
        bus.rd_used = 2'b10;
        push("raw_port1", 32'd1);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        bus.rd_used = 2'b00;
        push("raw_unused", 32'd0);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        set_rd(0, 5'd7);
        bus.rd_used = 2'b01;
        push("raw_port0", 32'd1);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        bus.iss_vld = 1'b0;
        push("raw_no_issue", 32'd0);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        idle();
    endtask

    task automatic test_writeback();
        wb(5'd7, 32'h0000_0055);
        bus.iss_vld = 1'b1;
        set_rd(1, 5'd7);
        bus.rd_used = 2'b10;
`ifdef RF_BYPASS_EN
        push("wb_stall_same", 32'd0);
        push("wb_data_same", 32'h0000_0055);
`else
        push("wb_stall_same", 32'd1);
        push("wb_data_same", 32'd0);
`endif
        #1;
        act = 32'(bus.stall);     pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[63:32]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        bus.wr_en = 1'b0;
        push("wb_stall_next", 32'd0);
        push("wb_data_next", 32'h0000_0055);
        push("wb_cnt_next", 32'd0);
        #1;
        act = 32'(bus.stall);     pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[63:32]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.busy_cnt);  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        idle();
    endtask

    task automatic test_waw();
        issue(5'd3);
        cyc();
        issue(5'd3);
        push("waw_stall", 32'd1);
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        push("waw_cnt_held", 32'd1);
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        wb(5'd3, 32'h0000_0033);
`ifdef RF_BYPASS_EN
        push("setclr_stall", 32'd0);
        push("setclr_cnt", 32'd1);
        push("setclr_busy3", 32'd1);
`else
        push("setclr_stall", 32'd1);
        push("setclr_cnt", 32'd0);
        push("setclr_busy3", 32'd0);
`endif
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        cyc();
        idle();
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        bus.iss_vld = 1'b1;
        set_rd(0, 5'd3);
        bus.rd_used = 2'b01;
        #1;
        act = 32'(bus.stall); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        idle();
        wb(5'd3, 32'h0000_0033);
        cyc();
        idle();
        push("waw_cleanup_cnt", 32'd0);
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
    endtask

    task automatic test_counter();
        for (int r = 1; r <= 3; r++) begin
            issue(5'(r));
            cyc();
            idle();
            push("cnt_issue", 32'(r));
            #1;
            act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        end
        issue(5'd0);
        cyc();
        idle();
        push("cnt_issue_r0", 32'd3);
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        wb(5'd2, 32'h0000_00A2);
        cyc();
        idle();
        push("cnt_wb2", 32'd2);
        #1;
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        issue(5'd5);
        wb(5'd1, 32'h0000_00AA);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd5);
        bus.iss_vld = 1'b1;
        bus.rd_used = 2'b11;
        push("midrst_cnt", 32'd0);
        push("midrst_rd1", 32'd0);
        push("midrst_rd5", 32'd0);
        push("midrst_stall", 32'd0);
        #1;
        act = 32'(bus.busy_cnt);  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[31:0];  pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = bus.rd_data[63:32]; pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        act = 32'(bus.stall);     pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int r = 10; r < 16; r++) begin
            d = $urandom();
            wb(5'(r), d);
            issue(5'(r + 6));
            push("b2b_read", d);
            cyc();
        end
        idle();
        push("b2b_cnt", 32'd6);
        for (int r = 10; r < 16; r++) begin
            set_rd(r % 2, 5'(r));
            #1;
            act = (r % 2 == 0) ? bus.rd_data[31:0] : bus.rd_data[63:32];
            pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
            cyc();
        end
        act = 32'(bus.busy_cnt); pop(); total++; if (act !== ev) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, ev); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_raw();
        test_writeback();
        test_waw();
        test_counter();
        test_back_to_back();
        if (name_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations: got %0d expected 0", name_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
